// File: rtl/bp_sacc_edge_concentrator.sv
// Edge concentrator for the streaming-accelerator column.
// Request side: round-robin, packet-atomic merge of per-row wormhole streams
// into one stream toward the CCE, buffered by a 2-entry output FIFO.
// Command side: zero-latency steering of one wormhole stream to the row
// selected by the header y coordinate; out-of-range packets are dropped.
//
// state  | meaning
// e_idle | waiting for a header flit; routing/arbitration decided per cycle
// e_busy | body flits of an accepted packet follow the latched row decision
module bp_sacc_edge_concentrator #(
  parameter int rows_p         = 2,
  parameter int flit_width_p   = 64,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int len_width_p    = 4,
  parameter int base_y_p       = 1
) (
  input  logic                           coh_clk_i,
  input  logic                           coh_reset_n_i,
  input  logic [rows_p-1:0]              req_v_i,
  input  logic [rows_p*flit_width_p-1:0] req_data_i,
  output logic [rows_p-1:0]              req_ready_and_o,
  output logic                           req_v_o,
  output logic [flit_width_p-1:0]        req_data_o,
  input  logic                           req_ready_and_i,
  input  logic                           cmd_v_i,
  input  logic [flit_width_p-1:0]        cmd_data_i,
  output logic                           cmd_ready_and_o,
  output logic [rows_p-1:0]              cmd_v_o,
  output logic [flit_width_p-1:0]        cmd_data_o,
  input  logic [rows_p-1:0]              cmd_ready_and_i,
  output logic                           err_o
);

  localparam int rr_width_lp = (rows_p > 1) ? $clog2(rows_p) : 1;
  localparam int y_lsb_lp    = x_cord_width_p;
  localparam int len_lsb_lp  = x_cord_width_p + y_cord_width_p;

  typedef enum logic {e_idle, e_busy} state_e;

  function automatic logic [rr_width_lp-1:0] wrap_inc(input logic [rr_width_lp-1:0] r);
    if (int'(r) >= rows_p - 1) return '0;
    else return r + rr_width_lp'(1);
  endfunction

  // live_r holds every ready/valid output low until the first clock after reset release
  logic live_r;

  // Release gate: low in reset, high from the first edge after release
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) live_r <= 1'b0;
    else                live_r <= 1'b1;
  end

  // ---------------- request path ----------------
  state_e                   req_state_r, req_state_n;
  logic [rr_width_lp-1:0]   rr_ptr_r, rr_ptr_n, grant_r, grant_n, acc_row;
  logic [len_width_p-1:0]   req_cnt_r, req_cnt_n, acc_len;
  logic                     acc_v;
  logic [flit_width_p-1:0]  acc_data;
  logic [flit_width_p-1:0]  fifo_mem [2];
  logic                     wr_ptr_r, rd_ptr_r;
  logic [1:0]               fifo_cnt_r;
  logic                     fifo_full, fifo_pop;
  logic                     blocked;
  int                       dist_j, dist_k;

  assign fifo_full = (fifo_cnt_r == 2'd2);
  assign fifo_pop  = req_v_o && req_ready_and_i;
  assign req_v_o   = (fifo_cnt_r != 2'd0);
  assign req_data_o = fifo_mem[rd_ptr_r];
  assign acc_len   = acc_data[len_lsb_lp +: len_width_p];

  // Per-row ready: a row is offered ready only if no row ahead of it in round-robin
  // order is valid, so a row's ready never depends on its own valid
  always_comb begin
    req_ready_and_o = '0;
    blocked = 1'b0;
    dist_j  = 0;
    dist_k  = 0;
    if (live_r && !fifo_full) begin
      if (req_state_r == e_busy) begin
        for (int j = 0; j < rows_p; j++)
          if (j == int'(grant_r)) req_ready_and_o[j] = 1'b1;
      end else begin
        for (int j = 0; j < rows_p; j++) begin
          blocked = 1'b0;
          dist_j  = (j - int'(rr_ptr_r) + rows_p) % rows_p;
          for (int k = 0; k < rows_p; k++) begin
            dist_k = (k - int'(rr_ptr_r) + rows_p) % rows_p;
            if (req_v_i[k] && (dist_k < dist_j)) blocked = 1'b1;
          end
          req_ready_and_o[j] = !blocked;
        end
      end
    end
  end

  // Select the accepted flit (at most one row handshakes per cycle)
  always_comb begin
    acc_v    = 1'b0;
    acc_row  = '0;
    acc_data = '0;
    for (int j = 0; j < rows_p; j++) begin
      if (req_v_i[j] && req_ready_and_o[j]) begin
        acc_v    = 1'b1;
        acc_row  = rr_width_lp'(j);
        acc_data = req_data_i[j*flit_width_p +: flit_width_p];
      end
    end
  end

  // Request FSM next state: header opens a packet, last body flit closes it
  always_comb begin
    req_state_n = req_state_r;
    rr_ptr_n    = rr_ptr_r;
    grant_n     = grant_r;
    req_cnt_n   = req_cnt_r;
    if (acc_v) begin
      case (req_state_r)
        e_idle: begin
          if (acc_len == '0) begin
            rr_ptr_n = wrap_inc(acc_row);
          end else begin
            req_cnt_n   = acc_len;
            grant_n     = acc_row;
            req_state_n = e_busy;
          end
        end
        e_busy: begin
          if (req_cnt_r == len_width_p'(1)) begin
            req_state_n = e_idle;
            rr_ptr_n    = wrap_inc(grant_r);
          end else begin
            req_cnt_n = req_cnt_r - len_width_p'(1);
          end
        end
        default: req_state_n = e_idle;
      endcase
    end
  end

  // Request FSM state register
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) begin
      req_state_r <= e_idle;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      req_cnt_r   <= '0;
    end else begin
      req_state_r <= req_state_n;
      rr_ptr_r    <= rr_ptr_n;
      grant_r     <= grant_n;
      req_cnt_r   <= req_cnt_n;
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) begin
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      if (acc_v)    wr_ptr_r <= ~wr_ptr_r;
      if (fifo_pop) rd_ptr_r <= ~rd_ptr_r;
      case ({acc_v, fifo_pop})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Output FIFO storage; contents are don't-care while empty
  always_ff @(posedge coh_clk_i) begin
    if (acc_v) fifo_mem[wr_ptr_r] <= acc_data;
  end

  // ---------------- command path ----------------
  state_e                   cmd_state_r, cmd_state_n;
  logic [rr_width_lp-1:0]   cmd_row_r, cmd_row_n, sel_row;
  logic                     cmd_drop_r, cmd_drop_n, sel_drop;
  logic [len_width_p-1:0]   cmd_cnt_r, cmd_cnt_n, cmd_len;
  logic [y_cord_width_p-1:0] cmd_y;
  int                       cmd_row_int;
  logic                     cmd_in_range, cmd_hs, err_r;

  assign cmd_y      = cmd_data_i[y_lsb_lp +: y_cord_width_p];
  assign cmd_len    = cmd_data_i[len_lsb_lp +: len_width_p];
  assign cmd_data_o = cmd_data_i;
  assign cmd_hs     = cmd_v_i && cmd_ready_and_o;
  assign err_o      = err_r;

  // Route decision: live header decode in idle, latched decision for body flits
  always_comb begin
    cmd_row_int  = int'(cmd_y) - base_y_p;
    cmd_in_range = (cmd_row_int >= 0) && (cmd_row_int < rows_p);
    if (cmd_state_r == e_idle) begin
      sel_drop = !cmd_in_range;
      sel_row  = cmd_in_range ? rr_width_lp'(cmd_row_int) : '0;
    end else begin
      sel_drop = cmd_drop_r;
      sel_row  = cmd_row_r;
    end
  end

  // Steer valid to the selected row and reflect that row's ready; drops always accept
  always_comb begin
    cmd_v_o         = '0;
    cmd_ready_and_o = 1'b0;
    if (live_r) begin
      if (sel_drop) begin
        cmd_ready_and_o = 1'b1;
      end else begin
        for (int j = 0; j < rows_p; j++) begin
          if (j == int'(sel_row)) begin
            cmd_v_o[j]      = cmd_v_i;
            cmd_ready_and_o = cmd_ready_and_i[j];
          end
        end
      end
    end
  end

  // Command FSM next state
  always_comb begin
    cmd_state_n = cmd_state_r;
    cmd_row_n   = cmd_row_r;
    cmd_drop_n  = cmd_drop_r;
    cmd_cnt_n   = cmd_cnt_r;
    if (cmd_hs) begin
      case (cmd_state_r)
        e_idle: begin
          if (cmd_len != '0) begin
            cmd_cnt_n   = cmd_len;
            cmd_row_n   = sel_row;
            cmd_drop_n  = sel_drop;
            cmd_state_n = e_busy;
          end
        end
        e_busy: begin
          if (cmd_cnt_r == len_width_p'(1)) cmd_state_n = e_idle;
          else cmd_cnt_n = cmd_cnt_r - len_width_p'(1);
        end
        default: cmd_state_n = e_idle;
      endcase
    end
  end

  // Command FSM state register and sticky drop flag
  always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
    if (!coh_reset_n_i) begin
      cmd_state_r <= e_idle;
      cmd_row_r   <= '0;
      cmd_drop_r  <= 1'b0;
      cmd_cnt_r   <= '0;
      err_r       <= 1'b0;
    end else begin
      cmd_state_r <= cmd_state_n;
      cmd_row_r   <= cmd_row_n;
      cmd_drop_r  <= cmd_drop_n;
      cmd_cnt_r   <= cmd_cnt_n;
      if (cmd_hs && (cmd_state_r == e_idle) && sel_drop) err_r <= 1'b1;
    end
  end

endmodule
